muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. Consumes the 5-bit ALU select code produced by the ALU control decoder (`ALU_MUL` … `ALU_REMU` from defines.v) together with the two register operands. Computes the 32-bit result over multiple cycles and signals completion with a start/busy/done handshake. Sits beside the single-cycle ALU in the execute stage; the datapath stalls on `busy`.

---
 rtl/muldiv_unit.sv | 210 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide on magnitudes, 32 iterations then a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  localparam logic [WIDTH-1:0]   ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ONE2     = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [5:0]         LAST_ITER = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [4:0]         op_q;
  logic               div_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  logic is_m_s, is_div_s, is_rem_s, a_signed_s, b_signed_s;
  logic sa_s, sb_s, special_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s, special_res_s;

  // Decode the select code into op class and operand signedness.
  always_comb begin
    is_m_s     = 1'b0;
    is_div_s   = 1'b0;
    is_rem_s   = 1'b0;
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (sel)
      ALU_MUL, ALU_MULH: begin
        is_m_s = 1'b1; a_signed_s = 1'b1; b_signed_s = 1'b1;
      end
      ALU_MULHSU: begin
        is_m_s = 1'b1; a_signed_s = 1'b1;
      end
      ALU_MULHU: is_m_s = 1'b1;
      ALU_DIV: begin
        is_m_s = 1'b1; is_div_s = 1'b1; a_signed_s = 1'b1; b_signed_s = 1'b1;
      end
      ALU_DIVU: begin
        is_m_s = 1'b1; is_div_s = 1'b1;
      end
      ALU_REM: begin
        is_m_s = 1'b1; is_div_s = 1'b1; is_rem_s = 1'b1; a_signed_s = 1'b1; b_signed_s = 1'b1;
      end
      ALU_REMU: begin
        is_m_s = 1'b1; is_div_s = 1'b1; is_rem_s = 1'b1;
      end
      default: is_m_s = 1'b0;
    endcase
  end

  // Operand magnitudes, signs and the divide corner cases resolved at accept.
  always_comb begin
    sa_s    = a_signed_s & a[WIDTH-1];
    sb_s    = b_signed_s & b[WIDTH-1];
    mag_a_s = sa_s ? ((~a) + ONE) : a;
    mag_b_s = sb_s ? ((~b) + ONE) : b;
    if (is_div_s && (b == ZERO)) begin
      special_s     = 1'b1;
      special_res_s = is_rem_s ? a : ALL_ONES;
    end else if (is_div_s && a_signed_s && (a == MIN_NEG) && (b == ALL_ONES)) begin
      special_s     = 1'b1;
      special_res_s = is_rem_s ? ZERO : MIN_NEG;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO;
    end
  end

  logic [WIDTH:0]     mul_sum_s, div_tmp_s, div_diff_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_s, quo_fix_s, rem_fix_s, result_fix_d;
  logic [2*WIDTH-1:0] acc_step_d, acc_neg_s, prod_fix_s;

  // One iteration step; acc holds {hi, lo} = {product hi, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {1'b0, ZERO});
    div_tmp_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_s = div_tmp_s - {1'b0, opb_q};
    div_ge_s   = ~div_diff_s[WIDTH];
    div_rem_s  = div_ge_s ? div_diff_s[WIDTH-1:0] : div_tmp_s[WIDTH-1:0];
    if (div_q) begin
      acc_step_d = {div_rem_s, acc_q[WIDTH-2:0], div_ge_s};
    end else begin
      acc_step_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and result selection for the FIX cycle.
  always_comb begin
    acc_neg_s  = (~acc_q) + ONE2;
    prod_fix_s = (sign_a_q ^ sign_b_q) ? acc_neg_s : acc_q;
    quo_fix_s  = (sign_a_q ^ sign_b_q) ? ((~acc_q[WIDTH-1:0]) + ONE) : acc_q[WIDTH-1:0];
    rem_fix_s  = sign_a_q ? ((~acc_q[2*WIDTH-1:WIDTH]) + ONE) : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      ALU_MUL:                        result_fix_d = prod_fix_s[WIDTH-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result_fix_d = prod_fix_s[2*WIDTH-1:WIDTH];
      ALU_DIV, ALU_DIVU:              result_fix_d = quo_fix_s;
      ALU_REM, ALU_REMU:              result_fix_d = rem_fix_s;
      default:                        result_fix_d = ZERO;
    endcase
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 5'd0;
      div_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= 6'd0;
      acc_q    <= {(2*WIDTH){1'b0}};
      opb_q    <= ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && is_m_s) begin
            op_q     <= sel;
            div_q    <= is_div_s;
            sign_a_q <= sa_s;
            sign_b_q <= sb_s;
            cnt_q    <= 6'd0;
            busy_q   <= 1'b1;
            if (special_s) begin
              result_q <= special_res_s;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              acc_q   <= is_div_s ? {ZERO, mag_a_s} : {ZERO, mag_b_s};
              opb_q   <= is_div_s ? mag_b_s : mag_a_s;
              done_q  <= 1'b0;
              state_q <= S_CALC;
            end
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        S_CALC: begin
          acc_q <= acc_step_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_FIX: begin
          result_q <= result_fix_d;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected results, latency and handshake checks.
module tb_muldiv_unit;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  sel = 5'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
    logic [7:0]  lat;
  } vec_t;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    logic [63:0] pu;
    logic signed [31:0] sx, sy, sq;
    sx = x;
    sy = y;
    case (op)
      ALU_MUL: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return p[31:0]; end
      ALU_MULH: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return p[63:32]; end
      ALU_MULHSU: begin p = $signed({{32{x[31]}}, x}) * $signed({32'd0, y}); return p[63:32]; end
      ALU_MULHU: begin pu = {32'd0, x} * {32'd0, y}; return pu[63:32]; end
      ALU_DIV: begin
        if (y == 32'd0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        sq = sx / sy; return sq;
      end
      ALU_REM: begin
        if (y == 32'd0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        sq = sx % sy; return sq;
      end
      ALU_DIVU: return (y == 32'd0) ? 32'hFFFFFFFF : x / y;
      ALU_REMU: return (y == 32'd0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic is_div;
    is_div = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    if (is_div && y == 32'd0) return 1;
    if ((op == ALU_DIV || op == ALU_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  // Called #1 after an edge: drives a one-cycle start, then scrambles the inputs.
  task automatic drive_start(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; sel = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; sel = ALU_ADD; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input int lat0, output logic [31:0] res, output int lat, output bit busy_ok);
    lat = lat0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    res = result;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, result} !== 34'd0) begin
      errors++; $display("FAIL reset_state busy=%b done=%b result=%h required 0 0 0", busy, done, result);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_plan_vectors();
    vec_t v[12];
    logic [31:0] res, e;
    int lat;
    bit bok;
    v = '{
      '{ALU_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 8'd34},
      '{ALU_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 8'd34},
      '{ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 8'd34},
      '{ALU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 8'd34},
      '{ALU_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 8'd34},
      '{ALU_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 8'd34},
      '{ALU_DIVU,   32'd100,        32'd7,        32'd14,       8'd34},
      '{ALU_REMU,   32'd100,        32'd7,        32'd2,        8'd34},
      '{ALU_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 8'd1},
      '{ALU_REMU,   32'd5,          32'd0,        32'd5,        8'd1},
      '{ALU_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 8'd1},
      '{ALU_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        8'd1}
    };
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(v[i].e);
      drive_start(v[i].op, v[i].x, v[i].y);
      wait_done(1, res, lat, bok);
      e = exp_q.pop_front();
      checks++;
      if (res !== e) begin errors++; $display("FAIL plan_result[%0d] got %h required %h", i, res, e); end
      checks++;
      if (lat != int'(v[i].lat)) begin errors++; $display("FAIL plan_latency[%0d] got %0d required %0d", i, lat, v[i].lat); end
      checks++;
      if (!bok) begin errors++; $display("FAIL plan_busy[%0d] got low while in flight required high", i); end
      @(posedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++; $display("FAIL plan_after_done[%0d] done=%b busy=%b required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, res, e;
    logic [4:0] op;
    int lat, el;
    bit bok;
    for (int i = 0; i < 24; i++) begin
      op = ALU_MUL + 5'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if (i % 6 == 2) y = 32'd0;
      if (i % 6 == 4) y = y >> $urandom_range(8, 30);
      if (i == 9) begin op = ALU_REM; x = 32'h80000000; y = 32'hFFFFFFFF; end
      exp_q.push_back(model(op, x, y));
      el = lat_model(op, x, y);
      drive_start(op, x, y);
      wait_done(1, res, lat, bok);
      e = exp_q.pop_front();
      checks++;
      if (res !== e) begin errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got %h required %h", i, op, x, y, res, e); end
      checks++;
      if (lat != el) begin errors++; $display("FAIL rand_latency[%0d] got %0d required %0d", i, lat, el); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] res, e;
    int lat;
    bit bok;
    exp_q.push_back(model(ALU_DIV, 32'd1000, 32'hFFFFFFF9));
    drive_start(ALU_DIV, 32'd1000, 32'hFFFFFFF9);
    repeat (9) begin @(posedge clk); #1; end
    start = 1'b1; sel = ALU_MUL; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(11, res, lat, bok);
    e = exp_q.pop_front();
    checks++;
    if (res !== e) begin errors++; $display("FAIL ignore_start_result got %h required %h", res, e); end
    checks++;
    if (lat != 34) begin errors++; $display("FAIL ignore_start_latency got %0d required 34", lat); end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL ignore_start_requeued done=%b busy=%b required 0 0", done, busy); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] res, e;
    int lat;
    bit bok;
    drive_start(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result} !== 34'd0) begin
      errors++; $display("FAIL midop_reset busy=%b done=%b result=%h required 0 0 0", busy, done, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(32'd14);
    drive_start(ALU_DIVU, 32'd100, 32'd7);
    wait_done(1, res, lat, bok);
    e = exp_q.pop_front();
    checks++;
    if (res !== e) begin errors++; $display("FAIL post_reset_result got %h required %h", res, e); end
    checks++;
    if (lat != 34) begin errors++; $display("FAIL post_reset_latency got %0d required 34", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_non_m();
    bit seen;
    logic [31:0] prev;
    prev = 32'd14;
    seen = 1'b0;
    drive_start(ALU_ADD, 32'd9, 32'd4);
    repeat (5) begin
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL non_m_start got busy/done activity required none"); end
    checks++;
    if (result !== prev) begin errors++; $display("FAIL non_m_result got %h required %h", result, prev); end
  endtask

  task automatic test_back_to_back();
    vec_t v[3];
    logic [31:0] res, e;
    int lat;
    bit bok;
    v = '{
      '{ALU_MUL,  32'h12345678, 32'h9ABCDEF0, 32'd0, 8'd0},
      '{ALU_REMU, 32'd77,       32'd0,        32'd0, 8'd0},
      '{ALU_DIV,  32'h80000001, 32'd3,        32'd0, 8'd0}
    };
    exp_q.push_back(model(ALU_DIVU, 32'd50, 32'd6));
    drive_start(ALU_DIVU, 32'd50, 32'd6);
    wait_done(1, res, lat, bok);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (res !== e) begin errors++; $display("FAIL b2b_result[%0d] got %h required %h", i, res, e); end
      // start held from the done cycle: only the cycle after done may accept it
      start = 1'b1; sel = v[i].op; a = v[i].x; b = v[i].y;
      exp_q.push_back(model(v[i].op, v[i].x, v[i].y));
      @(posedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL b2b_gap[%0d] done=%b busy=%b required 0 0", i, done, busy); end
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      wait_done(1, res, lat, bok);
      checks++;
      if (lat != lat_model(v[i].op, v[i].x, v[i].y)) begin
        errors++; $display("FAIL b2b_latency[%0d] got %0d required %0d", i, lat, lat_model(v[i].op, v[i].x, v[i].y));
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (res !== e) begin errors++; $display("FAIL b2b_result_last got %h required %h", res, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_random();
    test_ignore_start();
    test_reset_midop();
    test_non_m();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
